// File: rtl/vmem_fill_pkg.sv
// Shared definitions for the vmem rectangle-fill engine: register offsets,
// CTRL bit positions, FSM encoding and default screen geometry.
package vmem_fill_pkg;

  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_ORIGIN = 4'h4;
  localparam logic [3:0] REG_SIZE   = 4'h8;
  localparam logic [3:0] REG_COLOR  = 4'hC;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CLEAR = 2;

  localparam int SCREEN_W_DEF = 240;
  localparam int SCREEN_H_DEF = 240;
  localparam int COLOR_W_DEF  = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fill_state_e;

endpackage

// File: rtl/vmem_fill_raster.sv
// Raster walker for the fill engine: latches the rectangle at load and steps
// cx/cy in {y,x} raster order on each advance; coordinates wrap modulo 256.
module vmem_fill_raster (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] x0_i,
  input  logic [7:0] y0_i,
  input  logic [7:0] w_i,
  input  logic [7:0] h_i,
  input  logic       adv_i,
  output logic [7:0] cx_o,
  output logic [7:0] cy_o,
  output logic       last_o
);

  logic [7:0] x0_q;
  logic [7:0] xe_q;
  logic [7:0] ye_q;
  logic [7:0] cx_q;
  logic [7:0] cy_q;

  // End coordinates are precomputed so the last-pixel test is a plain compare.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x0_q <= '0;
      xe_q <= '0;
      ye_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
    end else if (load_i) begin
      x0_q <= x0_i;
      xe_q <= x0_i + w_i - 8'd1;
      ye_q <= y0_i + h_i - 8'd1;
      cx_q <= x0_i;
      cy_q <= y0_i;
    end else if (adv_i) begin
      if (cx_q == xe_q) begin
        cx_q <= x0_q;
        cy_q <= cy_q + 8'd1;
      end else begin
        cx_q <= cx_q + 8'd1;
      end
    end
  end

  assign cx_o   = cx_q;
  assign cy_o   = cy_q;
  assign last_o = (cx_q == xe_q) && (cy_q == ye_q);

endmodule

// File: rtl/vmem_rect_fill.sv
// Memory-mapped rectangle-fill engine owning vmem's write port; CPU stores
// always win the port. Define VMEM_FILL_CLIP_EN to suppress off-screen writes.
//
// Handshake: there is no ready path. cfg_we_i is a single-cycle strobe that is
// always accepted; cpu_vmem_we_i is always accepted and stalls the engine for
// that cycle; cfg_rdata_o reflects cfg_addr_i from the previous cycle.
module vmem_rect_fill
  import vmem_fill_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int COLOR_W  = COLOR_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cfg_we_i,
  input  logic [3:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o,
  input  logic               cpu_vmem_we_i,
  input  logic [15:0]        cpu_vmem_addr_i,
  input  logic [COLOR_W-1:0] cpu_vmem_wdata_i,
  output logic               vmem_we_o,
  output logic [15:0]        vmem_waddr_o,
  output logic [COLOR_W-1:0] vmem_wdata_o,
  output logic               busy_o,
  output logic               dbg_state_o
);

  fill_state_e        state_q, state_d;
  logic [15:0]        origin_q;
  logic [15:0]        size_q;
  logic [COLOR_W-1:0] color_q;
  logic [COLOR_W-1:0] run_color_q;
  logic               done_q;
  logic               err_q;

  logic       ctrl_we, start_req, abort_req, clear_req, zero_size;
  logic       load, eng_adv, eng_we, on_screen, fill_last, fill_done;
  logic [7:0] cx, cy;
  logic       unused_bits;

  assign ctrl_we   = cfg_we_i && (cfg_addr_i == REG_CTRL);
  // Abort dominates a simultaneous start, which makes start+abort a no-op in IDLE.
  assign start_req = ctrl_we && cfg_wdata_i[CTRL_START] && !cfg_wdata_i[CTRL_ABORT];
  assign abort_req = ctrl_we && cfg_wdata_i[CTRL_ABORT];
  assign clear_req = ctrl_we && cfg_wdata_i[CTRL_CLEAR];
  assign zero_size = (size_q[7:0] == 8'd0) || (size_q[15:8] == 8'd0);
  assign load      = (state_q == ST_IDLE) && start_req && !zero_size;
  assign fill_done = eng_adv && fill_last && !abort_req;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load) state_d = ST_RUN;
      ST_RUN: begin
        if (abort_req)      state_d = ST_IDLE;
        else if (fill_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q == ST_RUN);
    eng_adv = (state_q == ST_RUN) && !cpu_vmem_we_i;
    eng_we  = eng_adv && on_screen;
  end

`ifdef VMEM_FILL_CLIP_EN
  assign on_screen = ({24'd0, cx} < SCREEN_W) && ({24'd0, cy} < SCREEN_H);
`else
  assign on_screen = 1'b1;
`endif

  vmem_fill_raster u_raster (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (load),
    .x0_i   (origin_q[7:0]),
    .y0_i   (origin_q[15:8]),
    .w_i    (size_q[7:0]),
    .h_i    (size_q[15:8]),
    .adv_i  (eng_adv),
    .cx_o   (cx),
    .cy_o   (cy),
    .last_o (fill_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      origin_q    <= '0;
      size_q      <= '0;
      color_q     <= '0;
      run_color_q <= '0;
    end else begin
      if (cfg_we_i && (cfg_addr_i == REG_ORIGIN)) origin_q <= cfg_wdata_i[15:0];
      if (cfg_we_i && (cfg_addr_i == REG_SIZE))   size_q   <= cfg_wdata_i[15:0];
      if (cfg_we_i && (cfg_addr_i == REG_COLOR))  color_q  <= cfg_wdata_i[COLOR_W-1:0];
      if (load) run_color_q <= color_q;
    end
  end

  // Later assignments take priority: start outcome over clear, completion over both.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (clear_req) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if ((state_q == ST_IDLE) && start_req) begin
        done_q <= zero_size;
        err_q  <= zero_size;
      end
      if (fill_done) done_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_rdata_o <= '0;
    end else begin
      case (cfg_addr_i)
        REG_CTRL:   cfg_rdata_o <= {29'd0, err_q, done_q, busy_o};
        REG_ORIGIN: cfg_rdata_o <= {16'd0, origin_q};
        REG_SIZE:   cfg_rdata_o <= {16'd0, size_q};
        REG_COLOR:  cfg_rdata_o <= {{(32-COLOR_W){1'b0}}, color_q};
        default:    cfg_rdata_o <= '0;
      endcase
    end
  end

  always_comb begin
    if (cpu_vmem_we_i) begin
      vmem_we_o    = 1'b1;
      vmem_waddr_o = cpu_vmem_addr_i;
      vmem_wdata_o = cpu_vmem_wdata_i;
    end else begin
      vmem_we_o    = eng_we;
      vmem_waddr_o = {cy, cx};
      vmem_wdata_o = run_color_q;
    end
  end

  assign dbg_state_o = state_q;
  assign unused_bits = ^{cfg_wdata_i[31:16], SCREEN_W[0], SCREEN_H[0]};

endmodule
